// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state type for the AES scratch SRAM.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

  // NONSEQ and SEQ are the only transfer types that start a data phase.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_regfile.sv
// Word-wide scratch array: async clear, one synchronous write port, one combinational read port.
module ahb_slave_regfile
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDXW  = 6
) (
  input  logic            hclk,
  input  logic            hrst,
  input  logic            we,
  input  logic [IDXW-1:0] windex,
  input  logic [31:0]     wdata,
  input  logic [IDXW-1:0] rindex,
  output logic [31:0]     rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  // Next-state of every word: only the addressed word takes new data.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = (we && (windex == IDXW'(i))) ? wdata : mem_q[i];
    end
  end

  // Storage register with asynchronous clear.
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[rindex];

endmodule

// File: rtl/ahb_slave_sram.sv
// AHB-Lite single-word responder with programmable wait states and two-cycle ERROR response.
module ahb_slave_sram
  import ahb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int unsigned IDXW = $clog2(DEPTH);

  slv_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            write_q, write_d;
  logic [2:0]      cnt_q, cnt_d;

  logic [31:0]     offset_s;
  logic            accept_s;
  logic            legal_s;
  logic            we_s;
  logic [31:0]     rdata_s;

  // Unsigned wrap makes addresses below ADDR_BASE look huge, hence out of range.
  assign offset_s = haddr - ADDR_BASE;
  assign accept_s = hready & hsel & is_active(htrans);
  assign legal_s  = (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00) &&
                    ((offset_s >> 2) < 32'(DEPTH));

  // Next-state, address-phase capture and wait counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          if (legal_s) begin
            idx_d   = offset_s[IDXW+1:2];
            write_d = hwrite;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 3'(WAIT_STATES - 1);
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_ERR1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDXW{1'b0}};
      write_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus responses decode straight from the state flops.
  always_comb begin
    hready = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    if ((state_q == ST_ERR1) || (state_q == ST_ERR2)) begin
      hresp = HRESP_ERROR;
    end else begin
      hresp = HRESP_OKAY;
    end
    if ((state_q == ST_DATA) && !write_q) begin
      hrdata = rdata_s;
    end else begin
      hrdata = 32'h0000_0000;
    end
  end

  // The write lands on the edge that ends DATA, the same edge that may accept the next transfer.
  assign we_s = (state_q == ST_DATA) && write_q;

  ahb_slave_regfile #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_regfile (
    .hclk   (hclk),
    .hrst   (hrst),
    .we     (we_s),
    .windex (idx_q),
    .wdata  (hwdata),
    .rindex (idx_q),
    .rdata  (rdata_s)
  );

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Directed bench for ahb_slave_sram: one instance with one wait state, one with zero.
module tb_ahb_slave_sram;

  logic        hclk = 1'b0;
  logic        hrst = 1'b0;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic        sel_ws0 = 1'b0;

  logic        hsel_a, hsel_b;
  logic [31:0] hrdata_a, hrdata_b, hrdata_m;
  logic        hready_a, hready_b, hready_m;
  logic        hresp_a, hresp_b, hresp_m;

  int          checks = 0;
  int          failures = 0;

  logic [31:0] rd_v;
  int          st_v;
  logic        rs_v;

  assign hsel_a   = hsel & ~sel_ws0;
  assign hsel_b   = hsel & sel_ws0;
  assign hrdata_m = sel_ws0 ? hrdata_b : hrdata_a;
  assign hready_m = sel_ws0 ? hready_b : hready_a;
  assign hresp_m  = sel_ws0 ? hresp_b  : hresp_a;

  always #5 hclk = ~hclk;

  ahb_slave_sram #(.ADDR_BASE(32'h0000_0000), .DEPTH(64), .WAIT_STATES(1)) u_dut_ws1 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata_a), .hready(hready_a), .hresp(hresp_a)
  );

  ahb_slave_sram #(.ADDR_BASE(32'h0000_0000), .DEPTH(64), .WAIT_STATES(0)) u_dut_ws0 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata_b), .hready(hready_b), .hresp(hresp_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single transfer; starts and ends 1 time unit after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int stalls, output logic resp);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    stalls = 0;
    @(negedge hclk);
    while (!hready_m && stalls < 16) begin
      stalls++;
      @(negedge hclk);
    end
    rdata = hrdata_m;
    resp  = hresp_m;
    @(posedge hclk); #1;
  endtask

  task automatic err_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata; hsize = 3'b010;
    @(negedge hclk);
    check_eq({tag, "_err1_ready"}, 32'(hready_m), 32'd0);
    check_eq({tag, "_err1_resp"},  32'(hresp_m),  32'd1);
    @(negedge hclk);
    check_eq({tag, "_err2_ready"}, 32'(hready_m), 32'd1);
    check_eq({tag, "_err2_resp"},  32'(hresp_m),  32'd1);
    @(posedge hclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held: both instances at reset values.
    repeat (3) @(negedge hclk);
    check_eq("rst_ready_a", 32'(hready_a), 32'd1);
    check_eq("rst_resp_a",  32'(hresp_a),  32'd0);
    check_eq("rst_rdata_a", hrdata_a,      32'h0);
    check_eq("rst_ready_b", 32'(hready_b), 32'd1);
    check_eq("rst_resp_b",  32'(hresp_b),  32'd0);
    check_eq("rst_rdata_b", hrdata_b,      32'h0);
    @(posedge hclk); #1;
    hrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge hclk);
      check_eq("idle_ready", 32'(hready_m), 32'd1);
      check_eq("idle_resp",  32'(hresp_m),  32'd0);
      check_eq("idle_rdata", hrdata_m,      32'h0);
    end
    @(posedge hclk); #1;

    // One wait state: write then read back.
    xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd_v, st_v, rs_v);
    check_eq("ws1_wr_stalls", 32'(st_v), 32'd1);
    check_eq("ws1_wr_resp",   32'(rs_v), 32'd0);
    check_eq("ws1_wr_rdata",  rd_v,      32'h0);
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd_v, st_v, rs_v);
    check_eq("ws1_rd_stalls", 32'(st_v), 32'd1);
    check_eq("ws1_rd_resp",   32'(rs_v), 32'd0);
    check_eq("ws1_rd_data",   rd_v,      32'hDEADBEEF);

    // Master fetch pattern over four consecutive words.
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 32'(4 * i), 3'b010, 32'(i + 1), rd_v, st_v, rs_v);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 32'(4 * i), 3'b010, 32'h0, rd_v, st_v, rs_v);
      check_eq("fetch_data",   rd_v,      32'(i + 1));
      check_eq("fetch_stalls", 32'(st_v), 32'd1);
    end

    // Illegal accesses: two-cycle ERROR, memory untouched.
    err_xfer("oor",   1'b0, 32'h100, 3'b010, 32'h0);
    err_xfer("misal", 1'b1, 32'h2,   3'b010, 32'hFFFF_FFFF);
    err_xfer("size",  1'b1, 32'h4,   3'b000, 32'hFFFF_FFFF);
    xfer(1'b0, 32'h0, 3'b010, 32'h0, rd_v, st_v, rs_v);
    check_eq("err_keep_w0", rd_v, 32'h1);
    xfer(1'b0, 32'h4, 3'b010, 32'h0, rd_v, st_v, rs_v);
    check_eq("err_keep_w1", rd_v, 32'h2);
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd_v, st_v, rs_v);
    check_eq("err_keep_w4", rd_v, 32'hDEADBEEF);

    // Zero wait states: back-to-back write then read of the same word.
    sel_ws0 = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hwrite = 1'b0; hwdata = 32'h1;
    @(negedge hclk);
    check_eq("b2b_wr_ready", 32'(hready_m), 32'd1);
    check_eq("b2b_wr_resp",  32'(hresp_m),  32'd0);
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check_eq("b2b_rd_ready", 32'(hready_m), 32'd1);
    check_eq("b2b_rd_data",  hrdata_m,      32'h1);
    @(posedge hclk); #1;
    xfer(1'b0, 32'h0, 3'b010, 32'h0, rd_v, st_v, rs_v);
    check_eq("ws0_rd_stalls", 32'(st_v), 32'd0);
    check_eq("ws0_rd_data",   rd_v,      32'h1);
    sel_ws0 = 1'b0;

    // Reset during the wait state of a write.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h8; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hAA;
    @(negedge hclk);
    check_eq("mid_wait_ready", 32'(hready_m), 32'd0);
    #1 hrst = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(hready_m), 32'd1);
    check_eq("mid_rst_resp",  32'(hresp_m),  32'd0);
    check_eq("mid_rst_rdata", hrdata_m,      32'h0);
    @(posedge hclk); #1;
    hrst = 1'b1;
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd_v, st_v, rs_v);
    check_eq("mid_rst_rd_data",   rd_v,      32'h0);
    check_eq("mid_rst_rd_stalls", 32'(st_v), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_sram.md
# ahb_slave_sram

AHB-Lite responder that gives the AES accelerator's AHB master a word-addressed scratch memory to fetch plaintext blocks from and write ciphertext blocks into. It decodes single word transfers, inserts a programmable number of wait states, and returns a two-cycle ERROR response for illegal accesses. It sits on the bus opposite the master, in the accelerator test harness and SoC integration.

## Interface
- `ADDR_BASE`, 32'h0000_0000, byte address of word 0
- `DEPTH`, 64, number of 32-bit words (power of two, 4..256)
- `WAIT_STATES`, 1, data-phase wait cycles per valid transfer (0..7)
- `hclk` in 1: the single clock, rising edge
- `hrst` in 1: reset, asynchronous, active-low
- `hsel` in 1: slave select
- `haddr` in 32: byte address, address phase
- `htrans` in 2: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
- `hwrite` in 1: 1 = write, 0 = read
- `hsize` in 3: transfer size; only 3'b010 (word) is legal
- `hwdata` in 32: write data, data phase
- `hrdata` out 32: read data, valid when `hready`=1 in a read data phase
- `hready` out 1: transfer done / address phase accepted
- `hresp` out 1: 0 OKAY, 1 ERROR

## Operation
- Single-slave bus: `hready` out also qualifies the address phase. A transfer is accepted on a rising edge where `hready`=1, `hsel`=1 and `htrans[1]`=1. The edge latches addr, write and size.
- Legal transfer: `hsize`=010, `haddr[1:0]`=00, and (`haddr`-`ADDR_BASE`)>>2 < `DEPTH`, computed as 32-bit unsigned subtraction (underflow wraps, so it is out of range). Index = bits [log2(DEPTH)+1:2] of the difference.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: `hready`=1. Legal accept goes to WAIT if `WAIT_STATES`>0, else to DATA. Illegal accept goes to ERR1. No accept stays in IDLE.
  - WAIT: `hready`=0. The counter loads `WAIT_STATES`-1 on entry and decrements; at 0 the state goes to DATA.
  - DATA: `hready`=1, `hresp`=0. Read drives `hrdata`=mem[index]. Write stores `hwdata` into mem[index] on the edge that ends DATA. The same edge may accept a new transfer, with IDLE-state rules.
  - ERR1: `hready`=0, `hresp`=1. Always goes to ERR2.
  - ERR2: `hready`=1, `hresp`=1. Memory is untouched. The edge may accept a new transfer, with IDLE-state rules.
- IDLE/BUSY htrans, or `hsel`=0: no state change, OKAY.
- `hrdata`=0 outside a read DATA cycle.

## Timing
- Reset values: `hready`=1, `hresp`=0, `hrdata`=0, state IDLE, wait counter 0, all memory words 0.
- Transfer accepted at edge T with `WAIT_STATES`=N:
  - `hready`=0 in cycles T+1 .. T+N.
  - DATA (`hready`=1) in cycle T+N+1.
  - A write commits at the end of cycle T+N+1.
- N=0 gives zero-wait back-to-back transfers: one completes every cycle.
- Read-after-write to the same word, back-to-back: the read's DATA cycle returns the new value, because the write commits on the edge that accepts the read.
- Error: ERR1 at T+1, ERR2 at T+2, next accept earliest at the end of T+2. No wait states are inserted on errors.
- Inputs are ignored while `hready`=0. `hwdata` is sampled only at the end of a write DATA cycle.
- Reset asserted mid-transfer: the transfer is dropped, an uncommitted write is lost, and outputs take reset values immediately.

## Structure
- Package `ahb_pkg`:
  - htrans encodings and enum
  - HSIZE_WORD constant
  - HRESP_OKAY/HRESP_ERROR
  - slave state enum (IDLE, WAIT, DATA, ERR1, ERR2)
- Sub-module `ahb_slave_regfile`: `DEPTH`x32 array with async reset to 0, one synchronous write port (we, windex, wdata) and one combinational read port (rindex, rdata).
- The top holds the FSM, address-phase registers, the range decode and the wait counter.

## Test plan
- Reset then idle: with `hrst` low, `hready`=1, `hresp`=0, `hrdata`=0. After release with `htrans`=00 for 10 cycles, outputs are unchanged.
- `WAIT_STATES`=1: write 32'hDEADBEEF to 0x10, then read 0x10. Each transfer shows one `hready`=0 cycle, and the read DATA cycle returns 32'hDEADBEEF.
- `WAIT_STATES`=0: back-to-back NONSEQ write 0x0=32'h1 then read 0x0. Read returns 32'h1 with no stall cycle.
- Error cases, each giving ERR1 (`hready`=0,`hresp`=1) then ERR2 (`hready`=1,`hresp`=1) with memory unchanged:
  - read 0x100 with `DEPTH`=64
  - write 0x2 (misaligned)
  - `hsize`=000
- Master fetch pattern: read 0x0,0x4,0x8,0xC preloaded with 1..4 (via prior writes). Returns 1,2,3,4, each after `WAIT_STATES` stalls.
- Assert `hrst` during the wait state of a write to 0x8 = 32'hAA. Outputs are at reset values immediately, and a subsequent read of 0x8 returns 0.
